// File: rtl/friet_permutation_inverse_iterative_if.sv
// rtl/friet_permutation_inverse_iterative_if.sv - start/state/result bundle for the inverse Friet-P engine
interface friet_permutation_inverse_iterative_if;
    logic         start;
    logic [127:0] in_a;
    logic [127:0] in_b;
    logic [127:0] in_c;
    logic [127:0] in_d;
    logic [4:0]   round_index;
    logic [4:0]   rc_c;
    logic [4:0]   rc_d;
    logic         busy;
    logic         done;
    logic [127:0] out_a;
    logic [127:0] out_b;
    logic [127:0] out_c;
    logic [127:0] out_d;

    modport master (
        output start, in_a, in_b, in_c, in_d, rc_c, rc_d,
        input  round_index, busy, done, out_a, out_b, out_c, out_d
    );

    modport slave (
        input  start, in_a, in_b, in_c, in_d, rc_c, rc_d,
        output round_index, busy, done, out_a, out_b, out_c, out_d
    );
endinterface

// File: rtl/friet_permutation_inverse_iterative.sv
// rtl/friet_permutation_inverse_iterative.sv - iterative inverse Friet-P, one protected round per clock
module friet_permutation_inverse_iterative #(
    parameter int ROUNDS = 24
) (
    input logic clk,
    input logic rst,
    friet_permutation_inverse_iterative_if.slave bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam logic [4:0] LAST_ROUND = 5'(ROUNDS - 1);

    logic [1:0]   fsm_q, fsm_d;
    logic [4:0]   cnt_q, cnt_d;
    logic [127:0] a_q, b_q, c_q, d_q;
    logic [127:0] a_d, b_d, c_d, d_d;
    logic [127:0] rnd_a, rnd_b, rnd_c, rnd_d;

    friet_inv_round u_round (
        .a_i    (a_q),
        .b_i    (b_q),
        .c_i    (c_q),
        .d_i    (d_q),
        .rc_c_i (bus.rc_c),
        .rc_d_i (bus.rc_d),
        .a_o    (rnd_a),
        .b_o    (rnd_b),
        .c_o    (rnd_c),
        .d_o    (rnd_d)
    );

    always_comb begin
        fsm_d = fsm_q;
        cnt_d = cnt_q;
        a_d   = a_q;
        b_d   = b_q;
        c_d   = c_q;
        d_d   = d_q;
        case (fsm_q)
            // DONE accepts a new start exactly like IDLE so runs can be chained.
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    a_d   = bus.in_a;
                    b_d   = bus.in_b;
                    c_d   = bus.in_c;
                    d_d   = bus.in_d;
                    cnt_d = LAST_ROUND;
                    fsm_d = S_RUN;
                end else begin
                    fsm_d = S_IDLE;
                end
            end
            S_RUN: begin
                a_d = rnd_a;
                b_d = rnd_b;
                c_d = rnd_c;
                d_d = rnd_d;
                if (cnt_q == 5'd0) begin
                    fsm_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - 5'd1;
                end
            end
            default: fsm_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q <= S_IDLE;
            cnt_q <= 5'd0;
            a_q   <= '0;
            b_q   <= '0;
            c_q   <= '0;
            d_q   <= '0;
        end else begin
            fsm_q <= fsm_d;
            cnt_q <= cnt_d;
            a_q   <= a_d;
            b_q   <= b_d;
            c_q   <= c_d;
            d_q   <= d_d;
        end
    end

    assign bus.busy        = (fsm_q == S_RUN);
    assign bus.done        = (fsm_q == S_DONE);
    assign bus.round_index = cnt_q;
    assign bus.out_a       = a_q;
    assign bus.out_b       = b_q;
    assign bus.out_c       = c_q;
    assign bus.out_d       = d_q;
endmodule

// One inverse round built from per-bit cells so the AND/XOR ordering survives synthesis.
module friet_inv_round (
    input  logic [127:0] a_i,
    input  logic [127:0] b_i,
    input  logic [127:0] c_i,
    input  logic [127:0] d_i,
    input  logic [4:0]   rc_c_i,
    input  logic [4:0]   rc_d_i,
    output logic [127:0] a_o,
    output logic [127:0] b_o,
    output logic [127:0] c_o,
    output logic [127:0] d_o
);
    function automatic logic [127:0] rotl(input logic [127:0] x, input int unsigned n);
        return (x << n) | (x >> (128 - n));
    endfunction

    logic [127:0] c_r67, b_r36, t, d_p, f1, f1_r80, f2, a_n, a_r1, c_p;
    logic         nsel_c, nsel_d;

    assign c_r67  = rotl(c_i, 67);
    assign b_r36  = rotl(b_i, 36);
    assign f1_r80 = rotl(f1, 80);
    assign a_r1   = rotl(a_n, 1);
    assign a_o    = a_n;

    (* keep_hierarchy = "yes" *) friet_inv_cell u_nsel_c (.a_i(rc_c_i[4]), .y_o(nsel_c));
    (* keep_hierarchy = "yes" *) friet_inv_cell u_nsel_d (.a_i(rc_d_i[4]), .y_o(nsel_d));

    for (genvar j = 0; j < 128; j++) begin : g_bit
        (* keep_hierarchy = "yes" *) friet_and2_cell u_t   (.a_i(c_r67[j]), .b_i(b_r36[j]),  .y_o(t[j]));
        (* keep_hierarchy = "yes" *) friet_xor2_cell u_dp  (.a_i(a_i[j]),   .b_i(t[j]),      .y_o(d_p[j]));
        (* keep_hierarchy = "yes" *) friet_xor2_cell u_f1  (.a_i(d_i[j]),   .b_i(t[j]),      .y_o(f1[j]));
        (* keep_hierarchy = "yes" *) friet_xor2_cell u_a   (.a_i(c_i[j]),   .b_i(f1_r80[j]), .y_o(a_n[j]));
        (* keep_hierarchy = "yes" *) friet_xor2_cell u_f2  (.a_i(b_i[j]),   .b_i(f1_r80[j]), .y_o(f2[j]));
        (* keep_hierarchy = "yes" *) friet_xor2_cell u_b   (.a_i(f2[j]),    .b_i(a_r1[j]),   .y_o(b_o[j]));
        (* keep_hierarchy = "yes" *) friet_xor2_cell u_cp  (.a_i(f1[j]),    .b_i(a_r1[j]),   .y_o(c_p[j]));

        // Constant bit k lands on 4k when rc[4]=0, or on 4k+16 when rc[4]=1.
        if ((j % 4 == 0) && (j < 16)) begin : g_low
            (* keep_hierarchy = "yes" *) friet_xaon_cell u_kc (
                .a_i(c_p[j]), .b_i(rc_c_i[j / 4]), .c_i(nsel_c), .y_o(c_o[j]));
            (* keep_hierarchy = "yes" *) friet_xaon_cell u_kd (
                .a_i(d_p[j]), .b_i(rc_d_i[j / 4]), .c_i(nsel_d), .y_o(d_o[j]));
        end else if ((j % 4 == 0) && (j >= 16) && (j < 32)) begin : g_high
            (* keep_hierarchy = "yes" *) friet_xaon_cell u_kc (
                .a_i(c_p[j]), .b_i(rc_c_i[(j - 16) / 4]), .c_i(rc_c_i[4]), .y_o(c_o[j]));
            (* keep_hierarchy = "yes" *) friet_xaon_cell u_kd (
                .a_i(d_p[j]), .b_i(rc_d_i[(j - 16) / 4]), .c_i(rc_d_i[4]), .y_o(d_o[j]));
        end else begin : g_pass
            assign c_o[j] = c_p[j];
            assign d_o[j] = d_p[j];
        end
    end
endmodule

module friet_and2_cell (
    input  logic a_i,
    input  logic b_i,
    output logic y_o
);
    assign y_o = a_i & b_i;
endmodule

module friet_xor2_cell (
    input  logic a_i,
    input  logic b_i,
    output logic y_o
);
    assign y_o = a_i ^ b_i;
endmodule

module friet_inv_cell (
    input  logic a_i,
    output logic y_o
);
    assign y_o = ~a_i;
endmodule

// XOR-AND: y = a ^ (b & c), the gated constant injection cell.
module friet_xaon_cell (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic y_o
);
    assign y_o = a_i ^ (b_i & c_i);
endmodule

// File: doc/friet_permutation_inverse_iterative.md
Name: friet_permutation_inverse_iterative

Overview:
- Iterative engine that computes the inverse Friet-P permutation on a 512-bit state held as four 128-bit limbs a, b, c, d.
- Applies one inverse protected round per clock, from round ROUNDS-1 down to 0.
- Used on the decrypt/verify path opposite the forward round datapath.
- Round constants come from the shared constant table, indexed by the round_index output.

Parameters:
- ROUNDS, 24: number of inverse rounds per invocation; legal range 1..32.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request to run the permutation on in_a..in_d.
- in_a  input  128  limb a of the input state.
- in_b  input  128  limb b of the input state.
- in_c  input  128  limb c of the input state.
- in_d  input  128  limb d of the input state.
- round_index  output  5  round currently being undone; valid while busy.
- rc_c  input  5  c-limb round constant for round_index, combinational from the table.
- rc_d  input  5  d-limb round constant for round_index, combinational from the table.
- busy  output  1  high while rounds are executing.
- done  output  1  one-cycle pulse when the output state is valid.
- out_a  output  128  limb a of the result; held stable after done until the next accepted start.
- out_b  output  128  limb b of the result; same holding rule.
- out_c  output  128  limb c of the result; same holding rule.
- out_d  output  128  limb d of the result; same holding rule.

Behaviour:
- Reset (rst=1 at a clock edge):
  - FSM goes to IDLE; busy=0, done=0, round_index=0.
  - State registers and out_* go to 0.
  - Reset wins over start in the same cycle and aborts a run in progress; no done is produced.
- FSM states are IDLE, RUN and DONE.
  - IDLE: start=1 loads in_* into the state, sets the counter to ROUNDS-1 and moves to RUN.
  - RUN: applies one inverse round per cycle. At counter 0 the FSM moves to DONE, otherwise the counter decrements.
  - DONE: done=1 for exactly one cycle. start=1 here is accepted exactly as in IDLE (back-to-back runs); otherwise the FSM returns to IDLE.
- start is ignored while in RUN.
- Latency: start sampled at edge 0; busy=1 in cycles 1..ROUNDS; done=1 in cycle ROUNDS+1.
- round_index equals the counter while in RUN.
- out_* are the state registers directly, so intermediate values are visible during RUN.
- Notation: rotl(x,n) is a 128-bit left rotation, so result bit j = x[(j-n) mod 128]. & is AND, ^ is XOR.
- Inverse round, with (A,B,C,D) as the current state:
  - t = rotl(C,67) & rotl(B,36)
  - d' = A ^ t
  - f1 = D ^ t
  - a = C ^ rotl(f1,80)
  - f2 = B ^ rotl(f1,80)
  - b = f2 ^ rotl(a,1)
  - c' = f1 ^ rotl(a,1)
- Constant removal:
  - For j = 0..3, XOR rc_c[j] into c'[4j] when rc_c[4]=0, or into c'[4j+16] when rc_c[4]=1.
  - Apply the same rule with rc_d to d'.
  - The results are c and d; the new state is (a,b,c,d).
- Protection ordering: the AND, XOR and constant-XOR cells are instantiated per bit with keep_hierarchy, so synthesis cannot merge them. The constant gating uses the same inverter and XAON cell structure as the forward round.
- Correctness: one inverse round with constants (rc_c, rc_d) exactly undoes one forward round with the same constants. A full run with the table's constants inverts a full forward permutation.

Test Plan:
- Zero input: ROUNDS=24, state all zero, table constants → result equals the golden inverse vector from the software model; done in cycle 25; busy high in cycles 1..24.
- Constant placement: ROUNDS=1, zero state, rc_c=5'b00001, rc_d=0 → out_c has only bit 0 set; all other limbs 0.
  - rc_c=5'b10001 → only out_c[16] set.
  - rc_d=5'b11000 → only out_d[28] set.
- Single-bit D: ROUNDS=1, zero rc, in_d bit 0 only → out_a = bit 80; out_b = bits {80,81}; out_c = bits {0,81}; out_d = 0.
- Round trip: 1000 random states through the forward permutation model, then through the DUT → DUT output equals the original state every time.
- Handshake: start pulsed again in cycle 5 of a run → ignored, result unchanged. start held high on the done cycle → second run starts at once, done 25 cycles later.
- Reset mid-run: rst=1 in cycle 10 → busy=0, done never pulses, out_*=0. The next start runs normally.
